// File: rtl/window_linebuffer9x9_if.sv
// Pixel-stream and window-stream bundle for window_linebuffer9x9.
// Macro WLB_COORD_EN adds the win_row/win_col coordinate signals.
interface window_linebuffer9x9_if #(
  parameter int WIN   = 9,
  parameter int PIX_W = 7
`ifdef WLB_COORD_EN
  ,
  parameter int ROW_W = 5,
  parameter int COL_W = 5
`endif
);
  logic [PIX_W-1:0]         pix_in;
  logic                     pix_sof;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [WIN*WIN*PIX_W-1:0] win_data;
  logic                     win_valid;
  logic                     win_ready;
  logic                     win_last;
`ifdef WLB_COORD_EN
  logic [ROW_W-1:0]         win_row;
  logic [COL_W-1:0]         win_col;

  modport master (output pix_in, pix_sof, pix_valid, win_ready,
                  input  pix_ready, win_data, win_valid, win_last, win_row, win_col);
  modport slave  (input  pix_in, pix_sof, pix_valid, win_ready,
                  output pix_ready, win_data, win_valid, win_last, win_row, win_col);
`else
  modport master (output pix_in, pix_sof, pix_valid, win_ready,
                  input  pix_ready, win_data, win_valid, win_last);
  modport slave  (input  pix_in, pix_sof, pix_valid, win_ready,
                  output pix_ready, win_data, win_valid, win_last);
`endif
endinterface

// File: rtl/window_linebuffer9x9.sv
// Streaming WINxWIN sliding-window generator with line buffers and valid/ready output.
// Optional macro WLB_COORD_EN adds win_row/win_col (image coordinates of element (0,0)).
module window_linebuffer9x9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int WIN   = 9,
  parameter int PIX_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  window_linebuffer9x9_if.slave bus
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int LB_W  = (WIN - 1) * PIX_W;
  localparam int WD_W  = WIN * WIN * PIX_W;

  typedef enum logic [0:0] {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           state_r, state_nx_s;
  logic [ROW_W-1:0] row_r, row_nx_s, cur_row_s;
  logic [COL_W-1:0] col_r, col_nx_s, cur_col_s;
  logic             pix_ready_s, accept_s, take_s, emit_s, last_s;
  logic             win_valid_r, win_last_r;
  logic [WD_W-1:0]  win_r, win_nx_s;
  logic [LB_W-1:0]  lb_mem [IMG_W];
  logic [LB_W-1:0]  lb_rd_s, lb_wr_s;
  logic [PIX_W-1:0] col_s [WIN];

  assign pix_ready_s   = !win_valid_r || bus.win_ready;
  assign accept_s      = bus.pix_valid && pix_ready_s;
  assign bus.pix_ready = pix_ready_s;
  assign bus.win_valid = win_valid_r;
  assign bus.win_last  = win_last_r;
  assign bus.win_data  = win_r;

  // Next-state, raster position of the current beat, and window emit decision.
  always_comb begin
    state_nx_s = state_r;
    row_nx_s   = row_r;
    col_nx_s   = col_r;
    cur_row_s  = row_r;
    cur_col_s  = col_r;
    take_s     = 1'b0;
    last_s     = 1'b0;
    if (accept_s) begin
      if (bus.pix_sof) begin
        // An sof beat is pixel (0,0) whether idle or mid-frame (abort).
        take_s     = 1'b1;
        cur_row_s  = {ROW_W{1'b0}};
        cur_col_s  = {COL_W{1'b0}};
        row_nx_s   = {ROW_W{1'b0}};
        col_nx_s   = COL_W'(1);
        state_nx_s = ACTIVE;
      end else if (state_r == ACTIVE) begin
        take_s = 1'b1;
        if (col_r == COL_W'(IMG_W - 1)) begin
          col_nx_s = {COL_W{1'b0}};
          if (row_r == ROW_W'(IMG_H - 1)) begin
            row_nx_s   = {ROW_W{1'b0}};
            state_nx_s = WAIT_SOF;
            last_s     = 1'b1;
          end else begin
            row_nx_s = row_r + ROW_W'(1);
          end
        end else begin
          col_nx_s = col_r + COL_W'(1);
        end
      end else begin
        state_nx_s = WAIT_SOF;
      end
    end else begin
      take_s = 1'b0;
    end
    emit_s = take_s && (cur_row_s >= ROW_W'(WIN - 1)) && (cur_col_s >= COL_W'(WIN - 1));
  end

  // Column assembly from the line buffers and the shifted window.
  always_comb begin
    lb_rd_s = lb_mem[cur_col_s];
    lb_wr_s = {LB_W{1'b0}};
    for (int j = 0; j < WIN - 1; j++) col_s[j] = lb_rd_s[j*PIX_W +: PIX_W];
    col_s[WIN-1] = bus.pix_in;
    // Stored column drops its oldest row; entry 0 is always the oldest.
    for (int j = 0; j < WIN - 1; j++) lb_wr_s[j*PIX_W +: PIX_W] = col_s[j+1];
    win_nx_s = win_r;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++)
        win_nx_s[(r*WIN+c)*PIX_W +: PIX_W] = win_r[(r*WIN+c+1)*PIX_W +: PIX_W];
      win_nx_s[(r*WIN+WIN-1)*PIX_W +: PIX_W] = col_s[r];
    end
  end

  // Line-buffer storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (take_s) begin
      lb_mem[cur_col_s] <= lb_wr_s;
    end else begin
      lb_mem[cur_col_s] <= lb_mem[cur_col_s];
    end
  end

  // FSM state and raster counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= WAIT_SOF;
      row_r   <= {ROW_W{1'b0}};
      col_r   <= {COL_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      row_r   <= row_nx_s;
      col_r   <= col_nx_s;
    end
  end

  // Window output register; beats are only taken when the old window is free or consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_r       <= {WD_W{1'b0}};
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
    end else begin
      if (take_s) win_r <= win_nx_s;
      if (emit_s) begin
        win_valid_r <= 1'b1;
        win_last_r  <= last_s;
      end else if (bus.win_ready) begin
        win_valid_r <= 1'b0;
        win_last_r  <= 1'b0;
      end
    end
  end

`ifdef WLB_COORD_EN
  logic [ROW_W-1:0] win_row_r;
  logic [COL_W-1:0] win_col_r;

  // Coordinates of window element (0,0), captured with each emitted window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_row_r <= {ROW_W{1'b0}};
      win_col_r <= {COL_W{1'b0}};
    end else if (emit_s) begin
      win_row_r <= cur_row_s - ROW_W'(WIN - 1);
      win_col_r <= cur_col_s - COL_W'(WIN - 1);
    end else begin
      win_row_r <= win_row_r;
      win_col_r <= win_col_r;
    end
  end

  assign bus.win_row = win_row_r;
  assign bus.win_col = win_col_r;
`endif
endmodule
